// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - per-instruction fetch/decode/execute/memwb control FSM
// Issues one start pulse per stage, waits for its done, counts retirements and traps on illegal or timeout.
module stage_sequencer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             fetch_start,
  input  logic             fetch_done,
  output logic             decode_start,
  input  logic             decode_done,
  input  logic             illegal,
  output logic             execute_start,
  input  logic             execute_done,
  output logic             memwb_start,
  input  logic             memwb_done,
  output logic             retire,
  output logic [CNT_W-1:0] retired,
  output logic             busy,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       stage
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEMWB   = 3'd4,
    S_TRAP    = 3'd7
  } state_e;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_e           state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire_q, retire_d;
  logic             in_start, done_sel, done_ok, timed_out;

  // The wait counter is zero only in a stage's start cycle, so it doubles as the start flag.
  assign in_start  = (wait_q == 16'd0);
  assign done_ok   = done_sel && !in_start;
  assign timed_out = !done_ok && (wait_q == TIMEOUT_C);

  always_comb begin
    done_sel = 1'b0;
    case (state_q)
      S_FETCH:   done_sel = fetch_done;
      S_DECODE:  done_sel = decode_done;
      S_EXECUTE: done_sel = execute_done;
      S_MEMWB:   done_sel = memwb_done;
      default:   done_sel = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    cause_d   = cause_q;
    retired_d = retired_q;
    retire_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        wait_d = 16'd0;
        if (run) state_d = S_FETCH;
      end
      S_FETCH, S_DECODE, S_EXECUTE, S_MEMWB: begin
        wait_d = wait_q + 16'd1;
        if (done_ok) begin
          wait_d = 16'd0;
          case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
              if (illegal) begin
                state_d = S_TRAP;
                cause_d = 2'b01;
              end else begin
                state_d = S_EXECUTE;
              end
            end
            S_EXECUTE: state_d = S_MEMWB;
            default: begin
              retire_d  = 1'b1;
              retired_d = retired_q + CNT_W'(1);
              state_d   = run ? S_FETCH : S_IDLE;
            end
          endcase
        end else if (timed_out) begin
          wait_d  = 16'd0;
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      default: begin
        // Only reset leaves TRAP; unused encodings fall in here as well.
        state_d = S_TRAP;
        wait_d  = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wait_q    <= 16'd0;
      cause_q   <= 2'b00;
      retired_q <= '0;
      retire_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
      retire_q  <= retire_d;
    end
  end

  assign fetch_start   = (state_q == S_FETCH)   && in_start;
  assign decode_start  = (state_q == S_DECODE)  && in_start;
  assign execute_start = (state_q == S_EXECUTE) && in_start;
  assign memwb_start   = (state_q == S_MEMWB)   && in_start;
  assign retire        = retire_q;
  assign retired       = retired_q;
  assign busy          = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                         (state_q == S_EXECUTE) || (state_q == S_MEMWB);
  assign halted        = (state_q == S_IDLE);
  assign trap          = (state_q == S_TRAP);
  assign trap_cause    = cause_q;
  assign stage         = state_q;

endmodule
